// File: rtl/pma_types_1_12_pkg.sv
// Shared types and cause codes for the access-fault capture block.
package pma_types_1_12_pkg;

   typedef enum logic {FC_IDLE, FC_PENDING} fault_cap_state_t;

   localparam logic [3:0] CAUSE_I_ACC = 4'd1;
   localparam logic [3:0] CAUSE_L_ACC = 4'd5;
   localparam logic [3:0] CAUSE_S_ACC = 4'd7;

   // Data faults belong to the older instruction, so load beats store beats fetch.
   function automatic logic [3:0] win_cause(input logic ld, input logic st);
      if (ld)
         return CAUSE_L_ACC;
      else if (st)
         return CAUSE_S_ACC;
      else
         return CAUSE_I_ACC;
   endfunction

endpackage

// File: rtl/priv_1_12_sat_counter.sv
// Saturating up-counter; clear wins over increment.
module priv_1_12_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/priv_1_12_access_fault_capture.sv
// Qualifies and prioritises PMA/PMP access faults into one held exception
// record, stalls upstream while it is pending, and counts captures per class.
module priv_1_12_access_fault_capture
   import pma_types_1_12_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             pma_l_fault,
   input  logic             pma_s_fault,
   input  logic             pma_i_fault,
   input  logic             pmp_l_fault,
   input  logic             pmp_s_fault,
   input  logic             pmp_i_fault,
   input  logic [31:0]      daddr,
   input  logic [31:0]      iaddr,
   input  logic             ren,
   input  logic             wen,
   input  logic             xen,
   input  logic             flush,
   input  logic             fault_ack,
   input  logic             cnt_clr,
   output logic             fault_valid,
   output logic [3:0]       fault_cause,
   output logic [31:0]      fault_tval,
   output logic             fault_stall,
   output logic [CNT_W-1:0] cnt_l,
   output logic [CNT_W-1:0] cnt_s,
   output logic [CNT_W-1:0] cnt_i
);

   fault_cap_state_t state, state_n;
   logic [3:0]       cause_n;
   logic [31:0]      tval_n;
   logic             ld_q, st_q, if_q, any_q;
   logic             cap, cap_l, cap_s, cap_i;

   always_comb begin
      ld_q    = ren & (pma_l_fault | pmp_l_fault);
      st_q    = wen & (pma_s_fault | pmp_s_fault);
      if_q    = xen & (pma_i_fault | pmp_i_fault);
      any_q   = ld_q | st_q | if_q;
      state_n = state;
      cause_n = fault_cause;
      tval_n  = fault_tval;
      cap     = 1'b0;

      case (state)
         FC_IDLE:    cap = any_q;
         FC_PENDING: begin
            if (fault_ack) begin
               cap = any_q;
               if (!any_q) begin
                  state_n = FC_IDLE;
                  cause_n = '0;
                  tval_n  = '0;
               end
            end
         end
         default:    state_n = FC_IDLE;
      endcase

      // Flush discards both the held record and anything arriving this cycle.
      if (flush) begin
         cap     = 1'b0;
         state_n = FC_IDLE;
         cause_n = '0;
         tval_n  = '0;
      end

      if (cap) begin
         state_n = FC_PENDING;
         cause_n = win_cause(ld_q, st_q);
         tval_n  = (ld_q || st_q) ? daddr : iaddr;
      end

      cap_l = cap & ld_q;
      cap_s = cap & ~ld_q & st_q;
      cap_i = cap & ~ld_q & ~st_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= FC_IDLE;
         fault_cause <= '0;
         fault_tval  <= '0;
      end else begin
         state       <= state_n;
         fault_cause <= cause_n;
         fault_tval  <= tval_n;
      end
   end

   assign fault_valid = (state == FC_PENDING);
   assign fault_stall = fault_valid;

   priv_1_12_sat_counter #(.W(CNT_W)) u_cnt_l (
      .clk(CLK), .rst(RST), .inc(cap_l), .clr(cnt_clr), .count(cnt_l)
   );

   priv_1_12_sat_counter #(.W(CNT_W)) u_cnt_s (
      .clk(CLK), .rst(RST), .inc(cap_s), .clr(cnt_clr), .count(cnt_s)
   );

   priv_1_12_sat_counter #(.W(CNT_W)) u_cnt_i (
      .clk(CLK), .rst(RST), .inc(cap_i), .clr(cnt_clr), .count(cnt_i)
   );

endmodule
